// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive stimulus/capture stage: walks every N_WIDTH-bit vector in ascending order and
// compacts the one-bit response of the circuit under test into a MISR, a response map and a ones count.
module exhaustive_vector_sequencer #(
  parameter int                   N_WIDTH     = 4,
  parameter int                   HOLD_CYCLES = 1,
  parameter int                   SIG_WIDTH   = 16,
  parameter logic [SIG_WIDTH-1:0] POLY        = 16'h1021
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    dut_out,
  output logic [N_WIDTH-1:0]      N,
  output logic                    busy,
  output logic                    done,
  output logic                    sample_valid,
  output logic [N_WIDTH-1:0]      sample_vec,
  output logic                    sample_bit,
  output logic [SIG_WIDTH-1:0]    signature,
  output logic [N_WIDTH:0]        ones_count,
  output logic [2**N_WIDTH-1:0]   response_map,
  output logic [1:0]              fsm_state
);

  localparam int                 NUM_VEC   = 2 ** N_WIDTH;
  localparam logic [N_WIDTH-1:0] LAST_VEC  = {N_WIDTH{1'b1}};
  localparam logic [7:0]         HOLD_INIT = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [N_WIDTH-1:0]     vec_q, vec_d;
  logic [7:0]             hold_q, hold_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sv_q, sv_d;
  logic [N_WIDTH-1:0]     svec_q, svec_d;
  logic                   sbit_q, sbit_d;
  logic [SIG_WIDTH-1:0]   sig_q, sig_d;
  logic [N_WIDTH:0]       ones_q, ones_d;
  logic [NUM_VEC-1:0]     map_q, map_d;

  // One MISR step: shift, fold in the polynomial when the MSB falls out, inject the response at bit 0.
  logic [SIG_WIDTH-1:0]   sig_step;
  always_comb begin
    sig_step = {sig_q[SIG_WIDTH-2:0], 1'b0};
    if (sig_q[SIG_WIDTH-1]) begin
      sig_step = sig_step ^ POLY;
    end
    sig_step = sig_step ^ {{(SIG_WIDTH-1){1'b0}}, dut_out};
  end

  // start is a level request sampled on each rising edge; it is only acted on in IDLE or DONE,
  // so holding it high simply restarts the sweep on the first edge spent in DONE.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    sv_d    = 1'b0;
    svec_d  = svec_q;
    sbit_d  = sbit_q;
    sig_d   = sig_q;
    ones_d  = ones_q;
    map_d   = map_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sig_d   = '0;
          ones_d  = '0;
          map_d   = '0;
          vec_d   = '0;
          hold_d  = HOLD_INIT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        hold_d = hold_q - 8'd1;
        if (hold_q <= 8'd1) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        map_d[vec_q] = dut_out;
        ones_d       = ones_q + (N_WIDTH+1)'(dut_out);
        sig_d        = sig_step;
        sv_d         = 1'b1;
        svec_d       = vec_q;
        sbit_d       = dut_out;
        if (vec_q != LAST_VEC) begin
          vec_d   = vec_q + 1'b1;
          hold_d  = HOLD_INIT;
          state_d = S_APPLY;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sv_q    <= 1'b0;
      svec_q  <= '0;
      sbit_q  <= 1'b0;
      sig_q   <= '0;
      ones_q  <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sv_q    <= sv_d;
      svec_q  <= svec_d;
      sbit_q  <= sbit_d;
      sig_q   <= sig_d;
      ones_q  <= ones_d;
      map_q   <= map_d;
    end
  end

  assign N            = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sv_q;
  assign sample_vec   = svec_q;
  assign sample_bit   = sbit_q;
  assign signature    = sig_q;
  assign ones_count   = ones_q;
  assign response_map = map_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed bench for exhaustive_vector_sequencer: a table of response patterns with hand-computed
// results, plus sequences for reset abort, start during a run, held start and a longer hold time.
module tb_exhaustive_vector_sequencer;

  // ---------------- clock / reset ----------------
  logic CK = 1'b0;
  logic reset;
  always #5 CK = ~CK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT instances ----------------
  logic        start, start3;
  int          mode;
  logic        dut_out_m;

  logic [3:0]  N, sample_vec;
  logic        busy, done, sample_valid, sample_bit;
  logic [15:0] signature, response_map;
  logic [4:0]  ones_count;
  logic [1:0]  st;

  assign dut_out_m = (mode == 1) ? 1'b1 : (mode == 2) ? N[0] : 1'b0;

  exhaustive_vector_sequencer dut (
    .CK(CK), .reset(reset), .start(start), .dut_out(dut_out_m),
    .N(N), .busy(busy), .done(done), .sample_valid(sample_valid),
    .sample_vec(sample_vec), .sample_bit(sample_bit), .signature(signature),
    .ones_count(ones_count), .response_map(response_map), .fsm_state(st)
  );

  logic [3:0]  n3, svec3;
  logic        busy3, done3, sv3, sbit3;
  logic [15:0] sig3, map3;
  logic [4:0]  ones3;
  logic [1:0]  st3;

  exhaustive_vector_sequencer #(.HOLD_CYCLES(3)) dut3 (
    .CK(CK), .reset(reset), .start(start3), .dut_out(n3[0]),
    .N(n3), .busy(busy3), .done(done3), .sample_valid(sv3),
    .sample_vec(svec3), .sample_bit(sbit3), .signature(sig3),
    .ones_count(ones3), .response_map(map3), .fsm_state(st3)
  );

  // Narrow MISR so the feedback polynomial actually engages within one sweep.
  logic [3:0]  n8, svec8;
  logic        busy8, done8, sv8, sbit8;
  logic [7:0]  sig8;
  logic [15:0] map8;
  logic [4:0]  ones8;
  logic [1:0]  st8;

  exhaustive_vector_sequencer #(.SIG_WIDTH(8), .POLY(8'h07)) dut8 (
    .CK(CK), .reset(reset), .start(start), .dut_out(n8[0]),
    .N(n8), .busy(busy8), .done(done8), .sample_valid(sv8),
    .sample_vec(svec8), .sample_bit(sbit8), .signature(sig8),
    .ones_count(ones8), .response_map(map8), .fsm_state(st8)
  );

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q[$];   // {expected bit, expected vector}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input bit keep);
    start = 1'b1;
    @(posedge CK); #1;
    if (!keep) start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
  endtask

  task automatic collect(input int md, input int exp_cycles, input int poke);
    int         cyc;
    logic [4:0] e;
    exp_q.delete();
    for (int v = 0; v < 16; v++) begin
      logic b;
      b = (md == 1) ? 1'b1 : (md == 2) ? v[0] : 1'b0;
      exp_q.push_back({b, 4'(v)});
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc < 32 && (cyc % 8) == 7) check("n_drive", N, cyc / 2);
      if (cyc == poke)     start = 1'b1;
      if (cyc == poke + 2) start = 1'b0;
      @(posedge CK); #1;
      cyc++;
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_sample: got vec %0h with no pulse expected", sample_vec);
        end else begin
          e = exp_q.pop_front();
          check("sample_vec", sample_vec, e[3:0]);
          check("sample_bit", sample_bit, e[4]);
        end
      end
    end
    check("done_cycle", cyc, exp_cycles);
    check("pulses_left", exp_q.size(), 0);
    check("busy_at_done", busy, 0);
  endtask

  task automatic check_results(input string tag, input logic [15:0] sig, input logic [4:0] ones,
                               input logic [15:0] map);
    check({tag, "_signature"}, signature, sig);
    check({tag, "_ones"}, ones_count, ones);
    check({tag, "_map"}, response_map, map);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          mode;
    logic [15:0] sig;
    logic [4:0]  ones;
    logic [15:0] map;
    int          cycles;
  } vec_t;

  vec_t vt[3];

  initial begin
    vt[0] = '{mode: 0, sig: 16'h0000, ones: 5'd0,  map: 16'h0000, cycles: 32};
    vt[1] = '{mode: 1, sig: 16'hFFFF, ones: 5'd16, map: 16'hFFFF, cycles: 32};
    vt[2] = '{mode: 2, sig: 16'h5555, ones: 5'd8,  map: 16'hAAAA, cycles: 32};

    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 0;
    repeat (3) @(posedge CK);
    #1;
    check("rst_state", st, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_N", N, 0);
    check_results("rst", 16'h0000, 5'd0, 16'h0000);
    @(posedge CK); #1;
    reset = 1'b0;
    @(posedge CK); #1;

    // Table-driven sweeps.
    for (int i = 0; i < 3; i++) begin
      mode = vt[i].mode;
      pulse(1'b0);
      collect(vt[i].mode, vt[i].cycles, -10);
      check("done_high", done, 1);
      check_results($sformatf("tbl%0d", i), vt[i].sig, vt[i].ones, vt[i].map);
      check("done_holds_N", N, 15);
      @(posedge CK); #1;
    end

    // The narrow-MISR instance ran alongside the last table entry.
    check("misr8_signature", sig8, 8'hF9);
    check("misr8_ones", ones8, 5'd8);
    check("misr8_map", map8, 16'hAAAA);

    // Results hold in DONE.
    repeat (5) @(posedge CK);
    #1;
    check_results("done_hold", 16'h5555, 5'd8, 16'hAAAA);

    // start pulsed across an APPLY and a SAMPLE cycle has no effect.
    mode = 1;
    pulse(1'b0);
    collect(1, 32, 5);
    check_results("poke", 16'hFFFF, 5'd16, 16'hFFFF);

    // Reset mid-run aborts and clears everything immediately.
    mode = 2;
    @(posedge CK); #1;
    pulse(1'b0);
    repeat (13) @(posedge CK);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_N", N, 0);
    check("midrst_sv", sample_valid, 0);
    check("midrst_svec", sample_vec, 0);
    check("midrst_sbit", sample_bit, 0);
    check_results("midrst", 16'h0000, 5'd0, 16'h0000);
    @(posedge CK); #1;
    reset = 1'b0;
    @(posedge CK); #1;
    pulse(1'b0);
    collect(2, 32, -10);
    check_results("after_rst", 16'h5555, 5'd8, 16'hAAAA);

    // start held high: finish, then restart on the first edge in DONE.
    mode = 1;
    pulse(1'b1);
    collect(1, 32, -10);
    check_results("held_first", 16'hFFFF, 5'd16, 16'hFFFF);
    @(posedge CK); #1;
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_N", N, 0);
    check_results("restart_clear", 16'h0000, 5'd0, 16'h0000);
    mode = 2;
    collect(2, 32, -10);
    check_results("held_second", 16'h5555, 5'd8, 16'hAAAA);

    // HOLD_CYCLES=3 instance: N steps every 4 cycles, done at E0+64.
    begin
      int c;
      start3 = 1'b1;
      @(posedge CK); #1;
      start3 = 1'b0;
      c = 0;
      while (done3 !== 1'b1 && c < 400) begin
        if (c < 64 && ((c % 4) == 0 || (c % 4) == 3)) check("hold3_N", n3, c / 4);
        @(posedge CK); #1;
        c++;
      end
      check("hold3_done_cycle", c, 64);
      check("hold3_signature", sig3, 16'h5555);
      check("hold3_ones", ones3, 5'd8);
      check("hold3_map", map3, 16'hAAAA);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
